fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage that sits directly upstream of the decoder.
- Owns the PC and issues word reads to the instruction cache through the imemREN/imemaddr/ihit handshake.
- Buffers returned words in a small FIFO and presents them, with their PC, to the decode stage (instr_out drives the decoder's load input).
- Handles control-flow redirects (flush + new PC) and a sticky halt.

Parameters:
PC_INIT, 32'h0000_0000, PC value loaded at reset
DEPTH, 2, instruction FIFO entries (>=1)

Ports:
CLK  input  1  clock, rising edge
nRST  input  1  synchronous active-low reset
imemREN  output  1  instruction read request
imemaddr  output  32  word-aligned fetch address
imemload  input  32  instruction word; valid when ihit=1
ihit  input  1  read complete this cycle for imemaddr
redirect  input  1  flush and restart fetch at redirect_pc
redirect_pc  input  32  new fetch address; bits [1:0] ignored (forced 0)
halt  input  1  stop fetching (sticky until reset)
instr_ready  input  1  decode stage accepts head entry this cycle
instr_valid  output  1  head entry valid
instr_out  output  32  head instruction word (to decoder load)
instr_pc  output  32  PC of head instruction
instr_npc  output  32  instr_pc + 4
fetch_halted  output  1  halt state reached

Behaviour:
- Reset (nRST=0 at rising edge):
  - pc<=PC_INIT; FIFO count<=0; state<=RUN.
  - While nRST=0, imemREN is forced 0.
  - Reset mid-operation drops everything, including an in-flight request or a same-cycle ihit.
- States:
  - RUN: fetching.
  - HALTED: no requests; FIFO still drains.
  - Transitions: RUN->HALTED on halt=1. HALTED is left only by reset.
- Request:
  - imemREN = (state==RUN) && (count<DEPTH) && nRST.
  - imemaddr = pc with bits [1:0]=0, at all times.
  - imemaddr must stay stable while imemREN=1 and ihit=0. The cache may take any number of cycles.
  - ihit while imemREN=0 is ignored.
- Push: on ihit && imemREN && !redirect && !halt:
  - Write {imemload, pc} at the tail; count+1; pc<=pc+4.
  - Wrap modulo 2^32, no flag.
- Pop: on instr_valid && instr_ready, advance the head; count-1.
- Push and pop in the same cycle: count is unchanged; both take effect.
- Full: imemREN is 0, so no push. imemREN depends only on registered state and count, with no combinational path from instr_ready.
- Empty outputs:
  - instr_valid = (count!=0).
  - When empty: instr_out=32'h0000_0000 (sll $0 NOP), instr_pc=0, instr_npc=4. instr_ready is a don't-care.
- Redirect (in RUN) at an edge:
  - FIFO flushed (count<=0; a pop in that cycle is discarded).
  - pc<=redirect_pc & ~3.
  - A coincident ihit is dropped.
  - First request at the new PC goes out the next cycle.
- Halt at an edge:
  - state<=HALTED; a coincident ihit is dropped; pc is frozen.
  - halt has priority over redirect: a simultaneous redirect is ignored.
  - redirect in HALTED is ignored and does not flush.
- fetch_halted = (state==HALTED). It is registered and goes high the cycle after halt is sampled.
- FIFO pointers: modulo-DEPTH indices; count width $clog2(DEPTH+1).

Test Plan:
- Reset then ihit=1 every cycle, instr_ready=1, imem[i]=i*0x11 → addresses 0,4,8,12. instr_out sequence is 0x00,0x11,0x22 with instr_pc 0,4,8, starting one cycle after each hit.
- Cache miss: hold ihit=0 for 3 cycles at addr 0x8 → imemaddr stays 0x8 and imemREN=1 throughout. instr_valid=0 after the FIFO drains, and instr_out=0.
- Backpressure: instr_ready=0, ihit=1 → two pushes (PC 0,4), then imemREN=0 and imemaddr=0x8 held. Raising instr_ready pops PC 0, and imemREN returns to 1 the next cycle.
- Redirect with FIFO holding 2 entries and a coincident ihit, redirect_pc=0x103 → after the edge: count=0, instr_valid=0, imemaddr=0x100. The dropped word never appears.
- Halt with a coincident ihit and redirect → pc frozen, fetch_halted=1 next cycle, imemREN stays 0. Remaining FIFO entries still pop in order, and later redirects have no effect.
- Reset mid-miss (nRST=0 for 1 cycle while imemREN=1) → imemREN=0 during reset. Afterwards imemaddr=PC_INIT and instr_valid=0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word reads to the instruction cache
// and buffers returned words with their PC in a small FIFO for the decode stage.
module fetch_unit #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000,
    parameter int          DEPTH   = 2
) (
    input  logic        CLK,
    input  logic        nRST,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    input  logic [31:0] imemload,
    input  logic        ihit,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    input  logic        instr_ready,
    output logic        instr_valid,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_npc,
    output logic        fetch_halted
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR   = PW'(DEPTH - 1);

    typedef enum logic {
        RUN,
        HALTED
    } state_t;

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] pc;
    } entry_t;

    state_t          state;
    state_t          state_next;
    logic [31:0]     pc;
    logic [CW-1:0]   count;
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    entry_t          fifo [DEPTH];
    entry_t          head_entry;

    logic            running;
    logic            flush;
    logic            push;
    logic            pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    // Request depends only on registered state and count, never on instr_ready.
    assign running  = (state == RUN);
    assign imemREN  = running && (count < FULL_COUNT) && nRST;
    assign imemaddr = {pc[31:2], 2'b00};

    // Halt outranks redirect; both discard a coincident ihit.
    assign flush = running && redirect && !halt;
    assign push  = ihit && imemREN && !redirect && !halt;
    assign pop   = instr_valid && instr_ready;

    // State register
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (halt) state_next = HALTED;
            HALTED:  state_next = HALTED;
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            pc    <= PC_INIT;
            count <= '0;
            head  <= '0;
            tail  <= '0;
        end else if (flush) begin
            pc    <= redirect_pc & ~32'd3;
            count <= '0;
            head  <= '0;
            tail  <= '0;
        end else begin
            if (push) begin
                pc   <= pc + 32'd4;
                tail <= ptr_inc(tail);
            end
            if (pop) begin
                head <= ptr_inc(head);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: the FIFO storage has no reset; count alone decides which entries are meaningful.
    always_ff @(posedge CLK) begin
        if (push) begin
            fifo[tail] <= '{word: imemload, pc: pc};
        end
    end

    assign head_entry   = fifo[head];
    assign instr_valid  = (count != '0);
    assign instr_out    = instr_valid ? head_entry.word : 32'h0000_0000;
    assign instr_pc     = instr_valid ? head_entry.pc   : 32'h0000_0000;
    assign instr_npc    = instr_pc + 32'd4;
    assign fetch_halted = (state == HALTED);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: queue-based reference model compared every
// cycle, plus directed literal expectations for the main scenarios.
module tb_fetch_unit;

    localparam logic [31:0] PC_INIT = 32'h0000_0000;
    localparam int          DEPTH   = 2;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic [31:0] imemload;
    logic        ihit;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        instr_ready;
    logic        instr_valid;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic [31:0] instr_npc;
    logic        fetch_halted;

    fetch_unit #(.PC_INIT(PC_INIT), .DEPTH(DEPTH)) dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .imemREN      (imemREN),
        .imemaddr     (imemaddr),
        .imemload     (imemload),
        .ihit         (ihit),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .halt         (halt),
        .instr_ready  (instr_ready),
        .instr_valid  (instr_valid),
        .instr_out    (instr_out),
        .instr_pc     (instr_pc),
        .instr_npc    (instr_npc),
        .fetch_halted (fetch_halted)
    );

    always #5 CLK = ~CLK;

    // Instruction memory: word i holds i*0x11.
    assign imemload = (imemaddr >> 2) * 32'h11;

    int checks   = 0;
    int failures = 0;
    bit check_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: fetch PC, halted flag and a queue of {word, pc}.
    typedef struct packed {
        logic [31:0] word;
        logic [31:0] pc;
    } ent_t;

    ent_t        m_q[$];
    logic [31:0] m_pc     = PC_INIT;
    bit          m_halted = 1'b0;

    always @(posedge CLK) begin
        int n;
        bit mpop;
        bit mren;
        if (!nRST) begin
            m_pc = PC_INIT;
            m_q.delete();
            m_halted = 1'b0;
        end else begin
            n    = m_q.size();
            mpop = (n != 0) && instr_ready;
            mren = !m_halted && (n < DEPTH);
            if (!m_halted && halt) begin
                m_halted = 1'b1;
                if (mpop) void'(m_q.pop_front());
            end else if (!m_halted && redirect) begin
                m_q.delete();
                m_pc = redirect_pc & ~32'd3;
            end else begin
                if (mpop) void'(m_q.pop_front());
                if (mren && ihit) begin
                    m_q.push_back('{word: (m_pc >> 2) * 32'h11, pc: m_pc});
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    end

    always @(negedge CLK) begin
        logic        e_valid;
        logic [31:0] e_out;
        logic [31:0] e_pc;
        if (check_en) begin
            e_valid = (m_q.size() != 0);
            e_out   = e_valid ? m_q[0].word : 32'h0;
            e_pc    = e_valid ? m_q[0].pc   : 32'h0;
            check("m_imemREN", 32'(imemREN), 32'(nRST && !m_halted && (m_q.size() < DEPTH)));
            check("m_imemaddr", imemaddr, m_pc);
            check("m_instr_valid", 32'(instr_valid), 32'(e_valid));
            check("m_instr_out", instr_out, e_out);
            check("m_instr_pc", instr_pc, e_pc);
            check("m_instr_npc", instr_npc, e_pc + 32'd4);
            check("m_fetch_halted", 32'(fetch_halted), 32'(m_halted));
        end
    end

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    initial begin
        nRST = 1'b0; ihit = 1'b0; redirect = 1'b0; redirect_pc = '0;
        halt = 1'b0; instr_ready = 1'b0;
        tick();
        check_en = 1'b1;
        tick();
        #1 check("rst_ren_low", 32'(imemREN), 32'd0);

        // Reset state with streaming hits
        nRST = 1'b1; ihit = 1'b1; instr_ready = 1'b1;
        #1;
        check("rst_ren", 32'(imemREN), 32'd1);
        check("rst_addr", imemaddr, 32'h0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_out", instr_out, 32'h0);
        check("rst_npc", instr_npc, 32'h4);
        check("rst_halted", 32'(fetch_halted), 32'd0);
        tick(); #1;
        check("s1_out", instr_out, 32'h00);
        check("s1_pc", instr_pc, 32'h0);
        check("s1_addr", imemaddr, 32'h4);
        tick(); #1;
        check("s2_out", instr_out, 32'h11);
        check("s2_pc", instr_pc, 32'h4);
        check("s2_npc", instr_npc, 32'h8);
        check("s2_addr", imemaddr, 32'h8);

        // Cache miss at 0x8
        ihit = 1'b0;
        tick(); #1;
        check("miss_valid", 32'(instr_valid), 32'd0);
        check("miss_out", instr_out, 32'h0);
        check("miss_addr", imemaddr, 32'h8);
        tick(); tick(); #1;
        check("miss3_addr", imemaddr, 32'h8);
        check("miss3_ren", 32'(imemREN), 32'd1);
        ihit = 1'b1;
        tick(); #1;
        check("s3_out", instr_out, 32'h22);
        check("s3_pc", instr_pc, 32'h8);
        check("s3_addr", imemaddr, 32'hC);

        // Backpressure
        instr_ready = 1'b0;
        tick(); #1;
        check("bp_full_ren", 32'(imemREN), 32'd0);
        check("bp_full_addr", imemaddr, 32'h10);
        check("bp_head", instr_out, 32'h22);
        tick(); #1;
        check("bp_hold_addr", imemaddr, 32'h10);
        check("bp_hold_ren", 32'(imemREN), 32'd0);
        instr_ready = 1'b1;
        #1 check("bp_no_comb", 32'(imemREN), 32'd0);
        tick(); #1;
        check("bp_pop_out", instr_out, 32'h33);
        check("bp_pop_pc", instr_pc, 32'hC);
        check("bp_ren_back", 32'(imemREN), 32'd1);

        // Redirect with a full FIFO
        instr_ready = 1'b0;
        tick(); #1;
        check("pre_redir_ren", 32'(imemREN), 32'd0);
        redirect = 1'b1; redirect_pc = 32'h103; instr_ready = 1'b1;
        tick(); #1;
        check("redir_valid", 32'(instr_valid), 32'd0);
        check("redir_out", instr_out, 32'h0);
        check("redir_addr", imemaddr, 32'h100);
        check("redir_ren", 32'(imemREN), 32'd1);
        // Redirect with a live coincident hit at 0x100
        redirect_pc = 32'h202;
        tick(); #1;
        check("redir2_addr", imemaddr, 32'h200);
        check("redir2_valid", 32'(instr_valid), 32'd0);
        redirect = 1'b0; instr_ready = 1'b0;
        tick(); #1;
        check("post_redir_out", instr_out, 32'h880);
        check("post_redir_pc", instr_pc, 32'h200);
        check("post_redir_npc", instr_npc, 32'h204);

        // Halt with coincident hit and redirect
        halt = 1'b1; redirect = 1'b1; redirect_pc = 32'h400;
        tick(); #1;
        check("halt_flag", 32'(fetch_halted), 32'd1);
        check("halt_ren", 32'(imemREN), 32'd0);
        check("halt_addr", imemaddr, 32'h204);
        check("halt_head", instr_out, 32'h880);
        halt = 1'b0; redirect_pc = 32'h500;
        tick(); #1;
        check("halt_redir_ignored", imemaddr, 32'h204);
        check("halt_no_flush", 32'(instr_valid), 32'd1);
        instr_ready = 1'b1; redirect_pc = 32'h600;
        tick(); #1;
        check("halt_drain_valid", 32'(instr_valid), 32'd0);
        check("halt_drain_npc", instr_npc, 32'h4);
        check("halt_sticky", 32'(fetch_halted), 32'd1);
        redirect = 1'b0;

        // Reset leaves HALTED; then reset mid-miss with a same-cycle hit
        nRST = 1'b0; ihit = 1'b0;
        #1 check("rst2_ren_low", 32'(imemREN), 32'd0);
        tick();
        nRST = 1'b1;
        #1;
        check("rst2_addr", imemaddr, PC_INIT);
        check("rst2_halted", 32'(fetch_halted), 32'd0);
        check("rst2_ren", 32'(imemREN), 32'd1);
        tick();
        nRST = 1'b0; ihit = 1'b1;
        #1 check("rst3_ren_low", 32'(imemREN), 32'd0);
        tick();
        nRST = 1'b1; ihit = 1'b0;
        #1;
        check("rst3_addr", imemaddr, PC_INIT);
        check("rst3_valid", 32'(instr_valid), 32'd0);

        // PC wrap at the top of the address space
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        tick(); #1;
        check("wrap_addr", imemaddr, 32'hFFFF_FFFC);
        redirect = 1'b0; ihit = 1'b1; instr_ready = 1'b0;
        tick(); #1;
        check("wrap_out", instr_out, 32'h3FFF_FFEF);
        check("wrap_pc", instr_pc, 32'hFFFF_FFFC);
        check("wrap_npc", instr_npc, 32'h0);
        check("wrap_next_addr", imemaddr, 32'h0);

        // Mixed hit/ready pattern checked by the model
        for (int i = 0; i < 40; i++) begin
            ihit        = (i % 3) != 0;
            instr_ready = (i % 4) != 1;
            redirect    = (i == 20);
            redirect_pc = 32'h41;
            halt        = (i == 33);
            tick();
        end
        redirect = 1'b0; halt = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
